// File: rtl/layer_out_pkg.sv
// Shared types and sizing helpers for the layer output packer.
package layer_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2
    } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // A word index needs at least one bit even for single-word frames.
    function automatic int idx_width(input int n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

endpackage

// File: rtl/layer_out_capture.sv
// Per-neuron capture flags and activation buffer; first completion after arming wins.
module layer_out_capture #(
    parameter int N_NEURONS = 18,
    parameter int ACT_W     = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear_i,
    input  logic                         enable_i,
    input  logic [N_NEURONS*ACT_W-1:0]   act_i,
    input  logic [N_NEURONS-1:0]         done_i,
    output logic [N_NEURONS*ACT_W-1:0]   act_buf_o,
    output logic                         all_done_o
);

    logic [N_NEURONS-1:0] flags;

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
        logic             flag_q;
        logic [ACT_W-1:0] act_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                flag_q <= 1'b0;
                act_q  <= '0;
            end else if (clear_i) begin
                flag_q <= 1'b0;
            end else if (enable_i && done_i[gi] && !flag_q) begin
                flag_q <= 1'b1;
                act_q  <= act_i[gi*ACT_W +: ACT_W];
            end
        end

        assign flags[gi]                        = flag_q;
        assign act_buf_o[gi*ACT_W +: ACT_W]     = act_q;
    end

    // AND of registered flags so the FSM leaves ARMED one edge after the final capture.
    assign all_done_o = &flags;

endmodule

// File: rtl/axis_layer_output_packer.sv
// Collects per-neuron activations, then streams them packed into AXI4-Stream words.
module axis_layer_output_packer
    import layer_out_pkg::*;
#(
    parameter int N_NEURONS = 18,
    parameter int ACT_W     = 1,
    parameter int AXIS_W    = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [N_NEURONS*ACT_W-1:0]   act_i,
    input  logic [N_NEURONS-1:0]         done_i,
    output logic [AXIS_W-1:0]            m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic                         busy,
    output logic                         overrun
);

    localparam int PER_WORD  = AXIS_W / ACT_W;
    localparam int N_WORDS   = ceil_div(N_NEURONS, PER_WORD);
    localparam int WIDX_W    = idx_width(N_WORDS);
    localparam int ACT_BITS  = N_NEURONS * ACT_W;
    localparam int PAD_BITS  = N_WORDS * AXIS_W;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(N_WORDS - 1);

    if (ACT_W < 1 || (AXIS_W % ACT_W) != 0) begin : g_bad_width
        $error("ACT_W must be >= 1 and divide AXIS_W");
    end

    state_e              state_q, state_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic                overrun_q, overrun_d;
    logic                cap_clear;
    logic                all_done;
    logic [ACT_BITS-1:0] act_buf;
    logic [PAD_BITS-1:0] padded;

    layer_out_capture #(
        .N_NEURONS (N_NEURONS),
        .ACT_W     (ACT_W)
    ) u_capture (
        .clk        (clk),
        .rstn       (rstn),
        .clear_i    (cap_clear),
        .enable_i   (state_q == ARMED),
        .act_i      (act_i),
        .done_i     (done_i),
        .act_buf_o  (act_buf),
        .all_done_o (all_done)
    );

    // Slots past the last neuron read as zero.
    assign padded[ACT_BITS-1:0] = act_buf;
    if (PAD_BITS > ACT_BITS) begin : g_pad
        assign padded[PAD_BITS-1:ACT_BITS] = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            widx_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        overrun_d = overrun_q;
        cap_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ARMED;
                    widx_d    = '0;
                    overrun_d = 1'b0;
                    cap_clear = 1'b1;
                end
            end
            ARMED: begin
                if (all_done) begin
                    state_d = SEND;
                    widx_d  = '0;
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (widx_q == LAST_IDX) begin
                        state_d = IDLE;
                        widx_d  = '0;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (start && state_q != IDLE) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        m_axis_tvalid = (state_q == SEND);
        m_axis_tlast  = (state_q == SEND) && (widx_q == LAST_IDX);
        busy          = (state_q != IDLE);
        overrun       = overrun_q;
        m_axis_tdata  = '0;
        if (state_q == SEND) begin
            for (int w = 0; w < N_WORDS; w++) begin
                if (widx_q == WIDX_W'(w)) begin
                    m_axis_tdata = padded[w*AXIS_W +: AXIS_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_layer_output_packer.sv
// Randomised and directed frames on two packer configurations, checked against an arithmetic packing model.
module tb_axis_layer_output_packer;

    localparam int N = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // ACT_W = 1 instance (single word per frame)
    logic          start1, tready1;
    logic [N-1:0]  act1, done1;
    logic [31:0]   tdata1;
    logic          tvalid1, tlast1, busy1, overrun1;

    // ACT_W = 8 instance (five words per frame)
    logic          start8, tready8;
    logic [N*8-1:0] act8;
    logic [N-1:0]  done8;
    logic [31:0]   tdata8;
    logic          tvalid8, tlast8, busy8, overrun8;

    axis_layer_output_packer #(.N_NEURONS(N), .ACT_W(1), .AXIS_W(32)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .act_i(act1), .done_i(done1),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1),
        .m_axis_tready(tready1), .busy(busy1), .overrun(overrun1)
    );

    axis_layer_output_packer #(.N_NEURONS(N), .ACT_W(8), .AXIS_W(32)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .act_i(act8), .done_i(done8),
        .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tlast(tlast8),
        .m_axis_tready(tready8), .busy(busy8), .overrun(overrun8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int          dcyc[N];
    logic [7:0]  dact[N];
    logic [31:0] exp_w[5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Neuron j sits in word j/4, byte j%4; missing neurons contribute zero.
    task automatic build_expected8();
        for (int w = 0; w < 5; w++) begin
            exp_w[w] = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (w*4 + k < N) exp_w[w] = exp_w[w] + (32'(dact[w*4 + k]) << (8*k));
            end
        end
    endtask

    task automatic frame1(input logic [N-1:0] vals, input bit staggered);
        int maxd;
        maxd = 0;
        for (int i = 0; i < N; i++) begin
            dcyc[i] = staggered ? int'($urandom_range(1, 12)) : 1;
            if (dcyc[i] > maxd) maxd = dcyc[i];
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("d1_busy_after_start", 32'(busy1), 32'd1);
        for (int c = 1; c <= maxd; c++) begin
            for (int i = 0; i < N; i++) begin
                if (c == dcyc[i]) begin
                    done1[i] = 1'b1; act1[i] = vals[i];
                end else if (c > dcyc[i]) begin
                    done1[i] = 1'($urandom_range(0, 1)); act1[i] = 1'($urandom);
                end else begin
                    done1[i] = 1'b0; act1[i] = 1'($urandom);
                end
            end
            tick();
        end
        check("d1_tvalid_low_at_final_done", 32'(tvalid1), 32'd0);
        done1 = '0;
        act1  = ~vals;
        tick();
        tready1 = 1'b1;
        check("d1_tvalid", 32'(tvalid1), 32'd1);
        check("d1_tdata", tdata1, 32'(vals));
        check("d1_tlast", 32'(tlast1), 32'd1);
        tick();
        check("d1_tvalid_after_hs", 32'(tvalid1), 32'd0);
        check("d1_busy_after_hs", 32'(busy1), 32'd0);
    endtask

    // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic frame8(input int rmode, input bit start_mid, input bit prearm, input int abort_after);
        int  maxd, w, guard;
        bit  rdy;
        bit  pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        build_expected8();
        maxd = 0;
        for (int i = 0; i < N; i++) if (dcyc[i] > maxd) maxd = dcyc[i];
        if (prearm) begin
            done8 = '1;
            act8  = '1;
            tick();
            tick();
        end
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("d8_busy_after_start", 32'(busy8), 32'd1);
        check("d8_overrun_cleared", 32'(overrun8), 32'd0);
        for (int c = 1; c <= maxd; c++) begin
            for (int i = 0; i < N; i++) begin
                if (c == dcyc[i]) begin
                    done8[i] = 1'b1; act8[i*8 +: 8] = dact[i];
                end else if (c > dcyc[i]) begin
                    done8[i] = 1'($urandom_range(0, 1)); act8[i*8 +: 8] = 8'($urandom);
                end else begin
                    done8[i] = 1'b0; act8[i*8 +: 8] = 8'($urandom);
                end
            end
            tick();
        end
        check("d8_tvalid_low_at_final_done", 32'(tvalid8), 32'd0);
        tick();
        w = 0;
        guard = 0;
        while (w < 5 && guard < 200) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = pat[guard % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tready8 = rdy;
            check("d8_tvalid", 32'(tvalid8), 32'd1);
            check("d8_tdata", tdata8, exp_w[w]);
            check("d8_tlast", 32'(tlast8), 32'(w == 4));
            if (abort_after > 0 && w == abort_after) begin
                tready8 = 1'b0;
                #2 rstn = 1'b0;
                #1;
                check("rst_tvalid", 32'(tvalid8), 32'd0);
                check("rst_tlast", 32'(tlast8), 32'd0);
                check("rst_tdata", tdata8, 32'd0);
                check("rst_busy", 32'(busy8), 32'd0);
                check("rst_overrun", 32'(overrun8), 32'd0);
                #2 rstn = 1'b1;
                done8 = '0;
                return;
            end
            if (start_mid && guard == 1) start8 = 1'b1;
            tick();
            start8 = 1'b0;
            if (rdy) w++;
            guard++;
        end
        check("d8_frame_words", 32'(w), 32'd5);
        check("d8_tvalid_after_frame", 32'(tvalid8), 32'd0);
        check("d8_busy_after_frame", 32'(busy8), 32'd0);
        check("d8_overrun_after_frame", 32'(overrun8), 32'(start_mid));
        done8 = '0;
    endtask

    task automatic random_schedule();
        for (int i = 0; i < N; i++) begin
            dcyc[i] = int'($urandom_range(1, 20));
            dact[i] = 8'($urandom);
        end
    endtask

    initial begin
        rstn = 1'b0;
        start1 = 1'b0; tready1 = 1'b0; act1 = '0; done1 = '0;
        start8 = 1'b0; tready8 = 1'b0; act8 = '0; done8 = '0;
        #12;
        check("reset_tvalid1", 32'(tvalid1), 32'd0);
        check("reset_tlast1", 32'(tlast1), 32'd0);
        check("reset_tdata1", tdata1, 32'd0);
        check("reset_busy1", 32'(busy1), 32'd0);
        check("reset_overrun1", 32'(overrun1), 32'd0);
        check("reset_tvalid8", 32'(tvalid8), 32'd0);
        check("reset_tlast8", 32'(tlast8), 32'd0);
        check("reset_tdata8", tdata8, 32'd0);
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_overrun8", 32'(overrun8), 32'd0);
        rstn = 1'b1;
        tick();

        frame1(18'h2A5C3, 1'b0);
        frame1(18'($urandom), 1'b1);

        for (int i = 0; i < N; i++) begin
            dcyc[i] = 3 + i;
            dact[i] = 8'(i + 1);
        end
        frame8(0, 1'b0, 1'b0, 0);
        frame8(1, 1'b1, 1'b0, 0);

        random_schedule();
        frame8(2, 1'b0, 1'b1, 0);

        random_schedule();
        frame8(0, 1'b0, 1'b0, 2);
        tick();

        for (int r = 0; r < 4; r++) begin
            random_schedule();
            frame8(r % 3, r[0], 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_layer_output_packer.md
# axis_layer_output_packer

Parametrised output stage for one fully connected layer of the MNIST network. It collects N neuron activations, each `ACT_W` bits wide. Each neuron signals completion on its own `done` line at its own time. Once every neuron has completed, the block packs the captured activations into `AXIS_W`-bit words and streams them on an AXI4-Stream master with full backpressure and `tlast`. It sits between the neuron array of a layer and the DMA/next-layer stream interface.

## Interface
- `N_NEURONS`, 18: number of neurons (≥1).
- `ACT_W`, 1: bits per activation. Must be ≥1 and must divide `AXIS_W`.
- `AXIS_W`, 32: stream data width.
- Derived: `PER_WORD = AXIS_W/ACT_W` and `N_WORDS = ceil(N_NEURONS/PER_WORD)`.
- `clk`  in  1  clock.
- `rstn`  in  1  **reset, asynchronous, active-low.**
- `start`  in  1  arms a new collection; single-cycle pulse.
- `act_i`  in  `N_NEURONS*ACT_W`  activations; neuron i occupies `[i*ACT_W +: ACT_W]`.
- `done_i`  in  `N_NEURONS`  per-neuron completion; level or pulse.
- `m_axis_tdata`  out  `AXIS_W`  packed word.
- `m_axis_tvalid`  out  1  word valid.
- `m_axis_tlast`  out  1  high on word `N_WORDS-1`.
- `m_axis_tready`  in  1  downstream ready.
- `busy`  out  1  state ≠ IDLE.
- `overrun`  out  1  sticky: `start` arrived while not IDLE; cleared by the next accepted `start`.

## Operation
- The state machine has three states: IDLE, ARMED and SEND.
- **IDLE:** `start` clears all capture flags and goes to ARMED. `done_i` is ignored.
- **ARMED:** on each edge, for every neuron with `done_i[i]` high and its flag clear:
  - `act_i` slice is captured into the buffer;
  - the flag is set.
- **ARMED, capture rules:**
  - First capture wins; later `done_i` pulses or `act_i` changes for that neuron are ignored.
  - Simultaneous `done_i` on several neurons capture in the same cycle.
- **ARMED to SEND:** when all flags are set (registered AND), go to SEND with word index 0.
- **SEND:**
  - `tvalid` = 1.
  - `tdata` = word `widx`: neuron `j = widx*PER_WORD + k` drives bits `[k*ACT_W +: ACT_W]`.
  - Slots with j ≥ `N_NEURONS` are 0.
  - `tlast` = (`widx == N_WORDS-1`).
- **SEND, handshake:** on `tvalid & tready`, `widx` increments. The handshake on the last word returns to IDLE.
- `start` outside IDLE is ignored, apart from setting `overrun`.
- Capture buffer is frozen outside ARMED, so `tdata` is stable while `tvalid` is high and `tready` is low.
- Reset at any time returns to IDLE. All flags, buffer, `widx` and `overrun` clear, and a partially sent frame is abandoned (no `tlast`).

## Timing
- Reset values:
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0;
  - `busy` = 0, `overrun` = 0.
- `start` sampled at edge t: `busy` = 1 from t+1. Activations with `done_i` sampled at t are **not** captured.
- Final `done_i` sampled at edge d: flag set at d. `tvalid` rises after edge d+1 (SEND entered on d+1).
- Throughput: one word per cycle while `tready` = 1. Frame length is exactly `N_WORDS` handshakes.
- After the last handshake at edge e: `tvalid` = 0 and `busy` = 0 from e+1. A `start` at e+1 is accepted without overrun.
- AXI rules:
  - `tvalid` never depends combinationally on `tready`;
  - once high, `tvalid` stays high until the handshake.
- `tdata`/`tlast` may be a mux of registered state (buffer, `widx`). There is no combinational path from `act_i` or `done_i` to any output.

## Structure
- Package `layer_out_pkg`:
  - state enum {IDLE, ARMED, SEND};
  - function `ceil_div` for `N_WORDS`;
  - widths of `widx` via `$clog2(N_WORDS)` with a minimum of 1.
- One natural sub-module, `layer_out_capture`:
  - flag register plus buffer for all neurons;
  - inputs: clear, enable (ARMED), `act_i`, `done_i`;
  - outputs: buffer and `all_done`.
- FSM, word index and packing mux live in the top module.
- Elaboration-time check: `AXIS_W % ACT_W == 0`.

## Test plan
- **Basic frame (defaults N=18, ACT_W=1):**
  - stimulus: `start`; then all `done_i` in one cycle with `act_i = 18'h2A5C3`; `tready` = 1;
  - required: one word `32'h0002A5C3`, `tlast` = 1, `busy` low the cycle after the handshake.
- **Staggered, multi-word (N=18, ACT_W=8):**
  - stimulus: neuron i done at cycle 3+i with act = i+1; `act_i` changed after each done;
  - required: 5 words, `tdata` = 0x04030201, 0x08070605, … ; last word `32'h00001211` with `tlast` = 1; captured values unaffected by later `act_i` changes.
- **Backpressure:**
  - stimulus: `tready` toggling 1,0,0,1 during the multi-word frame;
  - required: `tdata`/`tlast` held while stalled; exactly 5 handshakes; no duplicate or skipped word.
- **Overrun and pre-arm done:**
  - stimulus: `start` asserted during SEND; `done_i` asserted in IDLE before `start`;
  - required: `overrun` = 1; frame unchanged; pre-start done not captured; a new `start` clears `overrun`.
- **Reset mid-frame:**
  - stimulus: `rstn` low asynchronously after word 2 of 5;
  - required: `tvalid` = 0 immediately; all outputs at reset values; the next frame starts at word 0 with fresh captures.
